// File: rtl/mac_sched.sv
// Round-robin scheduler sharing one 64x64 MAC (128-bit accumulator) among NUM_REQ requesters.
// Optional accumulator wrap detection is enabled by defining MAC_SCHED_OVF_EN.
module mac_sched #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         op_valid,
    input  logic [NUM_REQ*64-1:0]      op_a,
    input  logic [NUM_REQ*64-1:0]      op_b,
    output logic [NUM_REQ-1:0]         op_ready,
    output logic                       mac_clr,
    output logic [63:0]                mac_a,
    output logic [63:0]                mac_b,
    input  logic [127:0]               mac_acc,
    output logic                       res_valid,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic [127:0]               res_data,
    output logic                       res_ovf,
    input  logic                       res_ready,
    output logic [2:0]                 dbg_state
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int DCW = $clog2(MAC_LAT + 2) + 1;
    localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);

    // Handshakes: a job transfers on req_valid[i] & req_ready[i], an operand pair on
    // op_valid[id] & op_ready[id], a result on res_valid & res_ready; valid holds until accepted.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t             state, state_nx;
    logic [IDW-1:0]     rr_ptr, id_q;
    logic [LEN_W-1:0]   cnt;
    logic [DCW-1:0]     dcnt;

    logic [NUM_REQ-1:0] rot;
    logic [IDW-1:0]     off, gnt_idx, ptr_nx;
    logic [IDW:0]       gsum, gsum1;
    logic               gnt_found;
    logic [LEN_W-1:0]   len_sel;
    logic [63:0]        a_sel, b_sel;
    logic               v_sel;
    logic               hs;
    logic               drain_done;

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner.
    always_comb begin
        rot       = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
        gnt_found = 1'b0;
        off       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_found = 1'b1;
                off       = IDW'(k);
            end
        end
        gsum    = {1'b0, rr_ptr} + {1'b0, off};
        gnt_idx = (gsum >= NREQ) ? IDW'(gsum - NREQ) : gsum[IDW-1:0];
        gsum1   = {1'b0, gnt_idx} + (IDW+1)'(1);
        ptr_nx  = (gsum1 == NREQ) ? '0 : gsum1[IDW-1:0];
    end

    always_comb begin
        len_sel = '0;
        a_sel   = '0;
        b_sel   = '0;
        v_sel   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == IDW'(k)) len_sel = req_len[k*LEN_W +: LEN_W];
            if (id_q == IDW'(k)) begin
                a_sel = op_a[k*64 +: 64];
                b_sel = op_b[k*64 +: 64];
                v_sel = op_valid[k];
            end
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = '0;
        op_ready   = '0;
        hs         = 1'b0;
        drain_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (gnt_found) begin
                    req_ready = NUM_REQ'(1) << gnt_idx;
                    state_nx  = S_CLEAR;
                end
            end
            S_CLEAR:  state_nx = (cnt != '0) ? S_FEED : S_DRAIN;
            S_FEED: begin
                op_ready = NUM_REQ'(1) << id_q;
                hs       = v_sel;
                if (hs && cnt == LEN_W'(1)) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (dcnt == '0) begin
                    drain_done = 1'b1;
                    state_nx   = S_RESULT;
                end
            end
            S_RESULT: if (res_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign res_valid = (state == S_RESULT);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            id_q   <= '0;
            cnt    <= '0;
            dcnt   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        id_q   <= gnt_idx;
                        cnt    <= len_sel;
                        rr_ptr <= ptr_nx;
                    end
                end
                // A zero-length job holds one extra drain cycle behind the clear.
                S_CLEAR: dcnt <= (cnt == '0) ? DCW'(MAC_LAT + 1) : DCW'(MAC_LAT);
                S_FEED:  if (hs) cnt <= cnt - LEN_W'(1);
                S_DRAIN: if (dcnt != '0) dcnt <= dcnt - DCW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mac_clr  <= 1'b1;
            mac_a    <= '0;
            mac_b    <= '0;
            res_id   <= '0;
            res_data <= '0;
        end else begin
            mac_clr <= (state_nx == S_CLEAR);
            mac_a   <= hs ? a_sel : 64'd0;
            mac_b   <= hs ? b_sel : 64'd0;
            if (drain_done) begin
                res_id   <= id_q;
                res_data <= mac_acc;
            end
        end
    end

`ifdef MAC_SCHED_OVF_EN
    logic [127:0] acc_q;
    logic         ovf_sticky;
    logic         wrap;

    // Each step adds less than 2^128, so any wrap shows up as a decrease.
    assign wrap = (state == S_FEED || state == S_DRAIN) && (mac_acc < acc_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q      <= '0;
            ovf_sticky <= 1'b0;
            res_ovf    <= 1'b0;
        end else begin
            if (state == S_CLEAR) begin
                acc_q      <= '0;
                ovf_sticky <= 1'b0;
            end else if (state == S_FEED || state == S_DRAIN) begin
                acc_q      <= mac_acc;
                ovf_sticky <= ovf_sticky | wrap;
            end
            if (drain_done) res_ovf <= ovf_sticky | wrap;
        end
    end
`else
    assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_sched.sv
// Bench for mac_sched: directed vector table, round-robin and reset sequences, random jobs
// checked against a job-level model (round-robin order, wide dot-product sum, latency rules).
module tb_mac_sched;
    localparam int N  = 4;
    localparam int LW = 8;
    localparam int ML = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*LW-1:0]   req_len;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      op_valid;
    logic [N*64-1:0]   op_a, op_b;
    logic [N-1:0]      op_ready;
    logic              mac_clr;
    logic [63:0]       mac_a, mac_b;
    logic [127:0]      mac_acc;
    logic              res_valid;
    logic [1:0]        res_id;
    logic [127:0]      res_data;
    logic              res_ovf;
    logic              res_ready;
    logic [2:0]        dbg_state;

    mac_sched #(.NUM_REQ(N), .LEN_W(LW), .MAC_LAT(ML)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
        .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .res_ovf(res_ovf), .res_ready(res_ready), .dbg_state(dbg_state)
    );

    // clock / reset block and the shared MAC the scheduler drives
    always #5 clk = ~clk;

    logic [127:0] m_acc = '0;
    always @(posedge clk) begin
        if (mac_clr) m_acc <= '0;
        else         m_acc <= m_acc + 128'(mac_a) * 128'(mac_b);
    end
    assign mac_acc = m_acc;

    int tcyc = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // scoreboard state
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [127:0] exp_q[$];
    logic [63:0]  ja [N][8];
    logic [63:0]  jb [N][8];
    int           jl [N];
    int           m_ptr = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int id, input int len);
        jl[id] = len;
        req_len[id*LW +: LW] = LW'(len);
        req_valid[id] = 1'b1;
    endtask

    // Call with inputs settled shortly after a falling edge; returns just after a
    // falling edge inside the first IDLE cycle following the result accept.
    task automatic serve(input int gap_fix, input int gap_rand, input int stall, input int abort_at,
                         output int got_id, output logic [127:0] got_data, output int got_lat);
        int           g, len, k, gap, bound, bad_op, gstart;
        logic [191:0] sum;
        logic         exp_ovf, seen;
        logic [127:0] exp;
        got_id = -1; got_data = '0; got_lat = -1;
        g = model_grant();
        #1;
        bound = 0;
        while (req_ready == '0 && bound < 50) begin
            @(negedge clk); #1; bound++;
        end
        if (req_ready == '0 || g < 0) begin
            chk("grant_timeout", 128'(req_ready), 128'(1));
            return;
        end
        chk("grant_onehot", 128'(req_ready), 128'(N'(1) << g));
        len = jl[g];
        sum = '0;
        for (int i = 0; i < len; i++) sum += 192'(ja[g][i]) * 192'(jb[g][i]);
        exp_q.push_back(sum[127:0]);
`ifdef MAC_SCHED_OVF_EN
        exp_ovf = |sum[191:128];
`else
        exp_ovf = 1'b0;
`endif
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        m_ptr = (g + 1) % N;
        gstart = tcyc;
        k = 0; gap = 0; bad_op = 0; seen = 1'b0; bound = 0;
        while (!seen && bound < 400) begin
            @(negedge clk);
            if (k < len && gap == 0) begin
                op_valid[g] = 1'b1;
                op_a[g*64 +: 64] = ja[g][k];
                op_b[g*64 +: 64] = jb[g][k];
            end else begin
                op_valid[g] = 1'b0;
            end
            #1;
            if (op_ready != '0 && op_ready != (N'(1) << g)) bad_op++;
            if (len == 0 && op_ready != '0) bad_op++;
            if (op_valid[g] && op_ready[g]) begin
                k++;
                gap = gap_fix + $urandom_range(gap_rand, 0);
            end else if (gap > 0) begin
                gap--;
            end
            if (abort_at > 0 && k == abort_at) begin
                @(negedge clk);
                reset = 1'b0;
                op_valid = '0;
                #1;
                chk("rst_mac_clr", 128'(mac_clr), 128'(1));
                chk("rst_mac_a", 128'(mac_a), 128'(0));
                chk("rst_mac_b", 128'(mac_b), 128'(0));
                chk("rst_res_valid", 128'(res_valid), 128'(0));
                chk("rst_res_id", 128'(res_id), 128'(0));
                chk("rst_res_data", res_data, 128'(0));
                chk("rst_res_ovf", 128'(res_ovf), 128'(0));
                chk("rst_op_ready", 128'(op_ready), 128'(0));
                chk("rst_state", 128'(dbg_state), 128'(0));
                m_ptr = 0;
                exp_q.delete();
                return;
            end
            if (res_valid) seen = 1'b1;
            bound++;
        end
        op_valid[g] = 1'b0;
        if (!seen) begin
            chk("result_timeout", 128'(res_valid), 128'(1));
            return;
        end
        got_lat = tcyc - gstart;
        if (gap_fix == 0 && gap_rand == 0)
            chk("latency", 128'(got_lat), 128'((len == 0) ? ML + 3 : len + ML + 2));
        chk("op_ready_legal", 128'(bad_op), 128'(0));
        exp = exp_q.pop_front();
        chk("res_id", 128'(res_id), 128'(g));
        chk("res_data", res_data, exp);
        chk("res_ovf", 128'(res_ovf), 128'(exp_ovf));
        got_id = int'(res_id);
        got_data = res_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk); #1;
            chk("hold_valid", 128'(res_valid), 128'(1));
            chk("hold_data", res_data, exp);
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk); #1;
        chk("valid_drop", 128'(res_valid), 128'(0));
    endtask

    typedef struct {
        int           id;
        int           len;
        logic [63:0]  a0, b0, a1, b1, a2, b2;
        int           gap;
        int           stall;
        logic [127:0] exp_data;
        int           exp_lat;
    } vec_t;

    vec_t         tv [4];
    int           gid, glat;
    logic [127:0] gdat;
    int           rr_id  [5];
    logic [127:0] rr_dat [5];

    initial begin
        tv[0] = '{2, 3, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 0, 0, 128'd68, 6};
        tv[1] = '{1, 0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 0, 0, 128'd0, 4};
        tv[2] = '{3, 2, 64'd7, 64'd9, 64'd11, 64'd13, 64'd0, 64'd0, 3, 5, 128'd206, -1};
        tv[3] = '{0, 1, 64'd5, 64'd5, 64'd0, 64'd0, 64'd0, 64'd0, 0, 0, 128'd25, 4};
        rr_id  = '{0, 1, 2, 3, 0};
        rr_dat = '{128'd10, 128'd20, 128'd30, 128'd40, 128'd21};

        reset = 1'b0; req_valid = '0; req_len = '0; op_valid = '0;
        op_a = '0; op_b = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_mac_clr", 128'(mac_clr), 128'(1));
        chk("reset_res_valid", 128'(res_valid), 128'(0));
        chk("reset_res_data", res_data, 128'(0));
        chk("reset_mac_a", 128'(mac_a), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("clr_release", 128'(mac_clr), 128'(0));
        chk("idle_req_ready", 128'(req_ready), 128'(0));

        // directed vector table
        for (int v = 0; v < 4; v++) begin
            ja[tv[v].id][0] = tv[v].a0; jb[tv[v].id][0] = tv[v].b0;
            ja[tv[v].id][1] = tv[v].a1; jb[tv[v].id][1] = tv[v].b1;
            ja[tv[v].id][2] = tv[v].a2; jb[tv[v].id][2] = tv[v].b2;
            set_req(tv[v].id, tv[v].len);
            serve(tv[v].gap, 0, tv[v].stall, -1, gid, gdat, glat);
            chk("tv_id", 128'(gid), 128'(tv[v].id));
            chk("tv_data", gdat, tv[v].exp_data);
            if (tv[v].exp_lat >= 0) chk("tv_lat", 128'(glat), 128'(tv[v].exp_lat));
        end

        // reset in the middle of FEED, then a clean job with no residue
        for (int i = 0; i < 4; i++) begin
            ja[1][i] = 64'hFFFF_0000_0000_0000 + 64'(i); jb[1][i] = 64'h1234_5678;
        end
        set_req(1, 4);
        serve(0, 0, 0, 2, gid, gdat, glat);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("abort_clr_release", 128'(mac_clr), 128'(0));
        ja[3][0] = 64'd5; jb[3][0] = 64'd5;
        set_req(3, 1);
        serve(0, 0, 0, -1, gid, gdat, glat);
        chk("post_abort_data", gdat, 128'd25);

        // all four request together; requester 0 re-requests right after its grant
        for (int i = 0; i < N; i++) begin
            ja[i][0] = 64'(i + 1); jb[i][0] = 64'd10;
            set_req(i, 1);
        end
        for (int r = 0; r < 5; r++) begin
            serve(0, 0, 0, -1, gid, gdat, glat);
            chk("rr_id", 128'(gid), 128'(rr_id[r]));
            chk("rr_data", gdat, rr_dat[r]);
            if (r == 0) begin
                ja[0][0] = 64'd7; jb[0][0] = 64'd3;
                set_req(0, 1);
            end
        end

        // accumulator wrap, then a job that must start clean
        ja[1][0] = '1; jb[1][0] = '1; ja[1][1] = '1; jb[1][1] = '1;
        set_req(1, 2);
        serve(0, 0, 0, -1, gid, gdat, glat);
        chk("wrap_data", gdat, 128'h0 - (128'd1 << 66) + 128'd2);
        ja[2][0] = 64'd1; jb[2][0] = 64'd1;
        set_req(2, 1);
        serve(0, 0, 0, -1, gid, gdat, glat);
        chk("after_wrap_data", gdat, 128'd1);
        chk("after_wrap_ovf", 128'(res_ovf), 128'(0));

        // random jobs against the model
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(2, 0) == 0) begin
                    for (int p = 0; p < 4; p++) begin
                        ja[i][p] = {$urandom, $urandom};
                        jb[i][p] = ($urandom_range(1, 0) == 1) ? {$urandom, $urandom} : 64'($urandom_range(100, 0));
                    end
                    set_req(i, $urandom_range(4, 0));
                end
            end
            if (req_valid == '0) begin
                ja[it % N][0] = 64'($urandom); jb[it % N][0] = 64'($urandom);
                set_req(it % N, 1);
            end
            serve(0, $urandom_range(2, 0), $urandom_range(3, 0), -1, gid, gdat, glat);
        end
        while (req_valid != '0) serve(0, 0, 0, -1, gid, gdat, glat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
